// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: moves a WIDTH-bit operand by a run-time amount,
// at most STEP positions per clock, behind a start/busy/done handshake.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SHIFT | shifting, rem_q positions still to go
// S_DONE  | one-cycle result strobe; may accept a back-to-back start
module shift_unit_seq #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2,
  parameter int SHW   = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic [SHW-1:0]   amt_i,
  input  logic [1:0]       mode_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o,
  output logic             cout_o
);

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             cout_q, cout_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       mode_q, mode_d;
  logic             cin_q, cin_d;

  logic [WIDTH-1:0] step_w;
  logic             step_c;
  logic             last_step;

  // One clock's worth of shifting: up to STEP single-bit moves, cut short at rem_q.
  always_comb begin
    step_w = work_q;
    step_c = cout_q;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(rem_q)) begin
        case (mode_q)
          M_LSL: begin
            step_c = step_w[WIDTH-1];
            step_w = {step_w[WIDTH-2:0], cin_q};
          end
          M_LSR: begin
            step_c = step_w[0];
            step_w = {cin_q, step_w[WIDTH-1:1]};
          end
          M_ASR: begin
            step_c = step_w[0];
            step_w = {step_w[WIDTH-1], step_w[WIDTH-1:1]};
          end
          M_ROL: begin
            step_c = step_w[WIDTH-1];
            step_w = {step_w[WIDTH-2:0], step_w[WIDTH-1]};
          end
          default: ;
        endcase
      end
    end
  end

  assign last_step = (int'(rem_q) <= STEP);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cout_d  = cout_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          work_d  = in_i;
          rem_d   = amt_i;
          mode_d  = mode_i;
          cin_d   = cin_i;
          cout_d  = 1'b0;
          state_d = (amt_i == '0) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_d = step_w;
        cout_d = step_c;
        if (last_step) begin
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
          rem_d = rem_q - SHW'(STEP);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cout_q  <= 1'b0;
      rem_q   <= '0;
      mode_q  <= 2'b00;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cout_q  <= cout_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
    end
  end

  assign busy_o = (state_q == S_SHIFT);
  assign done_o = (state_q == S_DONE);
  assign out_o  = work_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq (WIDTH=8, STEP=2, SHW=3): directed vector table,
// handshake/reset sequences, and random jobs against an arithmetic reference.
module tb_shift_unit_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] in_v;
  logic [2:0] amt;
  logic [1:0] mode;
  logic       cin;
  logic       busy_o, done_o, cout_o;
  logic [7:0] out_o;

  int tests = 0;
  int fails = 0;

  shift_unit_seq #(.WIDTH(8), .STEP(2), .SHW(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .in_i(in_v), .amt_i(amt),
    .mode_i(mode), .cin_i(cin), .busy_o(busy_o), .done_o(done_o),
    .out_o(out_o), .cout_o(cout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] i;
    logic [2:0] a;
    logic [1:0] m;
    logic       c;
    logic [7:0] exp_out;
    logic       exp_cout;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: result of a single-bit shifts, computed with wide arithmetic.
  function automatic logic [8:0] model(input logic [7:0] i, input int a,
                                        input logic [1:0] m, input logic c);
    logic [15:0] v;
    logic [23:0] x;
    logic [7:0]  fill, o;
    logic        co;
    int          r;
    case (m)
      2'b00: begin
        v  = ({8'h00, i} << a) | (c ? 16'((1 << a) - 1) : 16'h0000);
        o  = v[7:0];
        co = v[8];
      end
      2'b01, 2'b10: begin
        fill = (m == 2'b10) ? {8{i[7]}} : {8{c}};
        x    = {fill, i, 8'h00} >> a;
        o    = x[15:8];
        co   = x[7];
      end
      default: begin
        r  = a % 8;
        o  = (i << r) | (i >> (8 - r));
        co = (a == 0) ? 1'b0 : o[0];
      end
    endcase
    return {co, o};
  endfunction

  task automatic wait_done(output int lat, output int busy_err);
    bit seen = 0;
    lat = 0;
    busy_err = 0;
    while (!seen && lat < 30) begin
      @(negedge clk);
      lat++;
      if (busy_o == done_o) busy_err++;
      if (done_o) seen = 1;
    end
  endtask

  task automatic run_job(input logic [7:0] i, input logic [2:0] a, input logic [1:0] m,
                         input logic c, output int lat, output int busy_err);
    @(negedge clk);
    in_v = i; amt = a; mode = m; cin = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, busy_err);
  endtask

  initial begin
    int lat, berr, dcnt;
    logic [8:0] ref_v;
    logic [7:0] ri;
    logic [2:0] ra;
    logic [1:0] rm;
    logic       rc;

    vecs[0] = '{8'hB3, 3'd3, 2'b00, 1'b1, 8'h9F, 1'b1, 3};
    vecs[1] = '{8'h84, 3'd5, 2'b10, 1'b0, 8'hFC, 1'b0, 4};
    vecs[2] = '{8'h84, 3'd5, 2'b01, 1'b0, 8'h04, 1'b0, 4};
    vecs[3] = '{8'h81, 3'd7, 2'b11, 1'b0, 8'hC0, 1'b0, 5};
    vecs[4] = '{8'h5A, 3'd0, 2'b00, 1'b1, 8'h5A, 1'b0, 1};
    vecs[5] = '{8'h0F, 3'd7, 2'b01, 1'b1, 8'hFE, 1'b0, 5};
    vecs[6] = '{8'h80, 3'd1, 2'b10, 1'b1, 8'hC0, 1'b0, 2};
    vecs[7] = '{8'h01, 3'd7, 2'b00, 1'b0, 8'h80, 1'b0, 5};

    rst_n = 1'b0; start = 1'b0; in_v = 8'hAA; amt = 3'd5; mode = 2'b11; cin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", 32'(out_o), 32'h0);
    chk("reset_cout", 32'(cout_o), 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);
    chk("reset_done", 32'(done_o), 32'h0);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      run_job(vecs[n].i, vecs[n].a, vecs[n].m, vecs[n].c, lat, berr);
      chk($sformatf("vec%0d_out", n), 32'(out_o), 32'(vecs[n].exp_out));
      chk($sformatf("vec%0d_cout", n), 32'(cout_o), 32'(vecs[n].exp_cout));
      chk($sformatf("vec%0d_lat", n), 32'(lat), 32'(vecs[n].exp_lat));
      chk($sformatf("vec%0d_busy", n), 32'(berr), 32'h0);
    end

    // start pulsed mid-job, with operand inputs changed, must not disturb it
    @(negedge clk);
    in_v = 8'h81; amt = 3'd7; mode = 2'b11; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; berr = 0; dcnt = 0;
    while (dcnt == 0 && lat < 30) begin
      @(negedge clk);
      lat++;
      if (busy_o == done_o) berr++;
      if (done_o) dcnt = 1;
      if (lat == 2) begin start = 1'b1; in_v = 8'hFF; amt = 3'd1; mode = 2'b00; cin = 1'b1; end
      if (lat == 3) start = 1'b0;
    end
    chk("ign_start_out", 32'(out_o), 32'hC0);
    chk("ign_start_cout", 32'(cout_o), 32'h0);
    chk("ign_start_lat", 32'(lat), 32'd5);
    chk("ign_start_busy", 32'(berr), 32'h0);

    // back-to-back start accepted in the done cycle
    in_v = 8'h01; amt = 3'd1; mode = 2'b00; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, berr);
    chk("b2b_out", 32'(out_o), 32'h02);
    chk("b2b_cout", 32'(cout_o), 32'h0);
    chk("b2b_lat", 32'(lat), 32'd2);

    // reset in the middle of a ROL job aborts it silently
    @(negedge clk);
    in_v = 8'h81; amt = 3'd7; mode = 2'b11; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_out", 32'(out_o), 32'h0);
    chk("abort_cout", 32'(cout_o), 32'h0);
    chk("abort_busy", 32'(busy_o), 32'h0);
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_o || busy_o) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'h0);
    run_job(8'hB3, 3'd3, 2'b00, 1'b1, lat, berr);
    chk("after_abort_out", 32'(out_o), 32'h9F);
    chk("after_abort_cout", 32'(cout_o), 32'h1);
    chk("after_abort_lat", 32'(lat), 32'd3);

    // random jobs against the reference
    for (int n = 0; n < 40; n++) begin
      ri = 8'($urandom_range(0, 255));
      ra = 3'($urandom_range(0, 7));
      rm = 2'($urandom_range(0, 3));
      rc = 1'($urandom_range(0, 1));
      ref_v = model(ri, int'(ra), rm, rc);
      run_job(ri, ra, rm, rc, lat, berr);
      chk($sformatf("rnd%0d_out i=%0h a=%0d m=%0d c=%0d", n, ri, ra, rm, rc),
          32'(out_o), 32'(ref_v[7:0]));
      chk($sformatf("rnd%0d_cout", n), 32'(cout_o), 32'(ref_v[8]));
      chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(1 + (int'(ra) + 1) / 2));
      chk($sformatf("rnd%0d_busy", n), 32'(berr), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
